// File: rtl/spi_master_if.sv
// Parallel handshake and SPI pin bundle for spi_master.
// Names carry the master's view: i_ = into the master, o_ = out of it.
interface spi_master_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  i_start;
   logic [DATA_WIDTH-1:0] i_tx_data;
   logic                  o_busy;
   logic                  o_done;
   logic [DATA_WIDTH-1:0] o_rx_data;
   logic                  o_sclk;
   logic                  o_mosi;
   logic                  i_miso;
   logic                  o_cs_n;

   modport master (
      input  i_start, i_tx_data, i_miso,
      output o_busy, o_done, o_rx_data, o_sclk, o_mosi, o_cs_n
   );

   modport slave (
      output i_start, i_tx_data, i_miso,
      input  o_busy, o_done, o_rx_data, o_sclk, o_mosi, o_cs_n
   );
endinterface

// File: rtl/spi_master.sv
// SPI master: one DATA_WIDTH-bit full-duplex transfer per accepted start,
// MSB first, fixed CPOL/CPHA. All outputs come straight from registers.
module spi_master #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 4,
   parameter bit CPOL       = 1'b0,
   parameter bit CPHA       = 1'b0
) (
   input  logic         i_clk,
   input  logic         i_reset,
   spi_master_if.master bus
);
   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EDGE_W = $clog2(2*DATA_WIDTH + 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2*DATA_WIDTH - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_HOLD} state_t;

   state_t                r_state,     w_state_nxt;
   logic [DIV_W-1:0]      r_div_cnt,   w_div_nxt;
   logic [EDGE_W-1:0]     r_edge_cnt,  w_edge_nxt;
   logic [DATA_WIDTH-1:0] r_tx_shift,  w_tx_nxt;
   logic [DATA_WIDTH-1:0] r_rx_shift,  w_rx_nxt;
   logic [DATA_WIDTH-1:0] r_rx_data,   w_rx_data_nxt;
   logic                  r_sclk,      w_sclk_nxt;
   logic                  r_mosi,      w_mosi_nxt;
   logic                  r_cs_n,      w_cs_n_nxt;
   logic                  r_busy,      w_busy_nxt;
   logic                  r_done,      w_done_nxt;

   logic w_div_end, w_lead, w_first, w_last, w_sample, w_shift;

   // Edge classification for the toggle about to happen (index = r_edge_cnt).
   assign w_div_end = (r_div_cnt == DIV_LAST);
   assign w_lead    = ~r_edge_cnt[0];
   assign w_first   = (r_edge_cnt == '0);
   assign w_last    = (r_edge_cnt == EDGE_LAST);
   // The first bit is already on mosi from SETUP, so the shift edge that
   // would precede it (CPHA=1 first leading) or follow the last bit
   // (CPHA=0 last trailing) is skipped.
   assign w_sample  = CPHA ? ~w_lead : w_lead;
   assign w_shift   = CPHA ? (w_lead & ~w_first) : (~w_lead & ~w_last);

   // Next-state and next-register values; everything defaults to hold.
   always_comb begin
      w_state_nxt   = r_state;
      w_div_nxt     = r_div_cnt;
      w_edge_nxt    = r_edge_cnt;
      w_tx_nxt      = r_tx_shift;
      w_rx_nxt      = r_rx_shift;
      w_rx_data_nxt = r_rx_data;
      w_sclk_nxt    = r_sclk;
      w_mosi_nxt    = r_mosi;
      w_cs_n_nxt    = r_cs_n;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.i_start) begin
               w_state_nxt = ST_SETUP;
               w_tx_nxt    = bus.i_tx_data;
               w_rx_nxt    = '0;
               w_edge_nxt  = '0;
               w_div_nxt   = '0;
               w_cs_n_nxt  = 1'b0;
               w_busy_nxt  = 1'b1;
               w_mosi_nxt  = bus.i_tx_data[DATA_WIDTH-1];
               w_sclk_nxt  = CPOL;
            end
         end
         ST_SETUP, ST_XFER: begin
            if (w_div_end) begin
               w_div_nxt   = '0;
               w_sclk_nxt  = ~r_sclk;
               w_edge_nxt  = r_edge_cnt + EDGE_W'(1);
               w_state_nxt = w_last ? ST_HOLD : ST_XFER;
               if (w_sample)
                  w_rx_nxt = {r_rx_shift[DATA_WIDTH-2:0], bus.i_miso};
               if (w_shift) begin
                  w_tx_nxt   = {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                  w_mosi_nxt = r_tx_shift[DATA_WIDTH-2];
               end
            end else begin
               w_div_nxt = r_div_cnt + DIV_W'(1);
            end
         end
         ST_HOLD: begin
            if (w_div_end) begin
               w_div_nxt     = '0;
               w_state_nxt   = ST_IDLE;
               w_done_nxt    = 1'b1;
               w_busy_nxt    = 1'b0;
               w_cs_n_nxt    = 1'b1;
               w_mosi_nxt    = 1'b0;
               w_sclk_nxt    = CPOL;
               w_rx_data_nxt = r_rx_shift;
            end else begin
               w_div_nxt = r_div_cnt + DIV_W'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any transfer silently.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_div_cnt  <= '0;
         r_edge_cnt <= '0;
         r_tx_shift <= '0;
         r_rx_shift <= '0;
         r_rx_data  <= '0;
         r_sclk     <= CPOL;
         r_mosi     <= 1'b0;
         r_cs_n     <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_div_cnt  <= w_div_nxt;
         r_edge_cnt <= w_edge_nxt;
         r_tx_shift <= w_tx_nxt;
         r_rx_shift <= w_rx_nxt;
         r_rx_data  <= w_rx_data_nxt;
         r_sclk     <= w_sclk_nxt;
         r_mosi     <= w_mosi_nxt;
         r_cs_n     <= w_cs_n_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
      end
   end

   assign bus.o_busy    = r_busy;
   assign bus.o_done    = r_done;
   assign bus.o_rx_data = r_rx_data;
   assign bus.o_sclk    = r_sclk;
   assign bus.o_mosi    = r_mosi;
   assign bus.o_cs_n    = r_cs_n;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three configurations (mode 0 loopback, mode 3 with
// a slave model, CLK_DIV=1/2-bit loopback) checked against cycle formulas.
module tb_spi_master;
   localparam int P_W   [3] = '{8, 8, 2};
   localparam int P_DIV [3] = '{4, 4, 1};
   localparam int P_CPOL[3] = '{0, 1, 0};
   localparam int P_CPHA[3] = '{0, 1, 0};

   logic       clk = 1'b0;
   logic       rst  [3];
   logic       start[3];
   logic [7:0] txd  [3];
   logic       sclk [3], cs_n[3], busy[3], done[3], mosi[3];
   logic [7:0] rx   [3];
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   spi_master_if #(.DATA_WIDTH(8)) ifA ();
   spi_master_if #(.DATA_WIDTH(8)) ifB ();
   spi_master_if #(.DATA_WIDTH(2)) ifC ();

   spi_master #(.DATA_WIDTH(8), .CLK_DIV(4), .CPOL(1'b0), .CPHA(1'b0))
      dutA (.i_clk(clk), .i_reset(rst[0]), .bus(ifA));
   spi_master #(.DATA_WIDTH(8), .CLK_DIV(4), .CPOL(1'b1), .CPHA(1'b1))
      dutB (.i_clk(clk), .i_reset(rst[1]), .bus(ifB));
   spi_master #(.DATA_WIDTH(2), .CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b0))
      dutC (.i_clk(clk), .i_reset(rst[2]), .bus(ifC));

   assign ifA.i_start = start[0];  assign ifA.i_tx_data = txd[0];
   assign ifB.i_start = start[1];  assign ifB.i_tx_data = txd[1];
   assign ifC.i_start = start[2];  assign ifC.i_tx_data = txd[2][1:0];
   assign ifA.i_miso  = ifA.o_mosi;
   assign ifC.i_miso  = ifC.o_mosi;

   assign sclk[0] = ifA.o_sclk; assign cs_n[0] = ifA.o_cs_n; assign busy[0] = ifA.o_busy;
   assign done[0] = ifA.o_done; assign mosi[0] = ifA.o_mosi; assign rx[0]   = ifA.o_rx_data;
   assign sclk[1] = ifB.o_sclk; assign cs_n[1] = ifB.o_cs_n; assign busy[1] = ifB.o_busy;
   assign done[1] = ifB.o_done; assign mosi[1] = ifB.o_mosi; assign rx[1]   = ifB.o_rx_data;
   assign sclk[2] = ifC.o_sclk; assign cs_n[2] = ifC.o_cs_n; assign busy[2] = ifC.o_busy;
   assign done[2] = ifC.o_done; assign mosi[2] = ifC.o_mosi; assign rx[2]   = {6'b0, ifC.o_rx_data};

   // Mode-3 slave on B: drives its next bit after each leading edge,
   // captures mosi after each trailing edge; rewinds while deselected.
   logic [7:0] s_word = 8'h00;
   logic [7:0] s_cap  = 8'h00;
   int         s_idx  = 0;
   logic       s_prev = 1'b1;
   always @(negedge clk) begin
      if (ifB.o_cs_n !== 1'b0) begin
         s_idx = 0;
         ifB.i_miso = 1'b0;
      end else if (ifB.o_sclk !== s_prev) begin
         if (ifB.o_sclk == 1'b0) begin
            if (s_idx < 8) ifB.i_miso = s_word[7-s_idx];
         end else begin
            s_cap = {s_cap[6:0], ifB.o_mosi};
            s_idx++;
         end
      end
      s_prev = ifB.o_sclk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs cycles 1..done of a transfer already requested in cycle 0 and
   // checks every pin against the cycle-number rules. hold keeps start high
   // (with tx_data scrambled) until the done cycle; chain requests nxt in
   // the done cycle.
   task automatic xfer(input int d, input logic [7:0] tx, input logic [7:0] exp_rx,
                       input bit hold, input bit chain, input logic [7:0] nxt);
      int w, dv, done_c, n, idx;
      int e_sclk, e_cs, e_busy, e_done, e_mosi;
      logic in_x, exp_sclk, exp_mosi;
      w = P_W[d]; dv = P_DIV[d]; done_c = 1 + dv*(2*w + 1);
      e_sclk = 0; e_cs = 0; e_busy = 0; e_done = 0; e_mosi = 0;
      for (int c = 1; c <= done_c; c++) begin
         @(negedge clk);
         if (c == 1 && !hold) start[d] = 1'b0;
         if (hold) txd[d] = 8'($urandom);
         if (hold && c == done_c) start[d] = 1'b0;
         n = (c - 1) / dv;
         if (n > 2*w) n = 2*w;
         exp_sclk = bit'(P_CPOL[d]) ^ n[0];
         in_x = (c < done_c);
         if (P_CPHA[d] != 0) idx = (n == 0) ? 0 : ((n + 1)/2 - 1);
         else                idx = n / 2;
         if (idx > w - 1) idx = w - 1;
         exp_mosi = in_x ? tx[w-1-idx] : 1'b0;
         if (sclk[d] !== exp_sclk)     e_sclk++;
         if (cs_n[d] !== !in_x)        e_cs++;
         if (busy[d] !== in_x)         e_busy++;
         if (done[d] !== (c == done_c)) e_done++;
         if (mosi[d] !== exp_mosi)     e_mosi++;
         if (c == done_c) begin
            chk($sformatf("rx_data dut%0d tx=%0h", d, tx), 32'(rx[d]), 32'(exp_rx));
            if (chain) begin start[d] = 1'b1; txd[d] = nxt; end
         end
      end
      chk($sformatf("sclk_bad_cycles dut%0d", d), 32'(e_sclk), 0);
      chk($sformatf("cs_n_bad_cycles dut%0d", d), 32'(e_cs),   0);
      chk($sformatf("busy_bad_cycles dut%0d", d), 32'(e_busy), 0);
      chk($sformatf("done_bad_cycles dut%0d", d), 32'(e_done), 0);
      chk($sformatf("mosi_bad_cycles dut%0d", d), 32'(e_mosi), 0);
      if (!chain) begin
         @(negedge clk);
         chk($sformatf("idle_after dut%0d", d), {28'd0, sclk[d], cs_n[d], busy[d], done[d]},
             {28'd0, bit'(P_CPOL[d]), 1'b1, 1'b0, 1'b0});
      end
   endtask

   task automatic go(input int d, input logic [7:0] tx, input logic [7:0] exp_rx, input bit hold);
      @(negedge clk);
      start[d] = 1'b1;
      txd[d]   = tx;
      xfer(d, tx, exp_rx, hold, 1'b0, 8'h00);
   endtask

   initial begin
      logic [7:0] t, s;
      int seen;
      for (int d = 0; d < 3; d++) begin rst[d] = 1'b1; start[d] = 1'b0; txd[d] = 8'h00; end
      // Reset overrides a pending start.
      start[0] = 1'b1;
      repeat (3) @(negedge clk);
      start[0] = 1'b0;
      for (int d = 0; d < 3; d++)
         chk($sformatf("reset_state dut%0d", d),
             {23'd0, sclk[d], cs_n[d], mosi[d], busy[d], done[d], rx[d]},
             {23'd0, bit'(P_CPOL[d]), 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;

      // Reset at cycle 30 of a transfer: pins idle next cycle, no done, rx kept.
      @(negedge clk);
      start[0] = 1'b1; txd[0] = 8'h96;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 1) start[0] = 1'b0;
      end
      rst[0] = 1'b1;
      @(negedge clk);
      chk("mid_reset_pins", {28'd0, sclk[0], cs_n[0], busy[0], mosi[0]}, {28'd0, 1'b0, 1'b1, 1'b0, 1'b0});
      rst[0] = 1'b0;
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (done[0] === 1'b1) seen++;
      end
      chk("mid_reset_no_done", 32'(seen), 0);
      chk("mid_reset_rx_kept", 32'(rx[0]), 32'h0);

      // Mode 0 loopback, directed then random.
      go(0, 8'hA5, 8'hA5, 1'b0);
      for (int i = 0; i < 5; i++) begin
         t = 8'($urandom);
         go(0, t, t, 1'b0);
      end
      // start held high with tx_data churning: one transfer of the cycle-0 word.
      go(0, 8'h3E, 8'h3E, 1'b1);
      repeat (20) begin
         @(negedge clk);
         if (done[0] === 1'b1) seen++;
      end
      chk("hold_no_extra_done", 32'(seen), 0);
      // Back-to-back: second start lands in the done cycle.
      go(0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      start[0] = 1'b1; txd[0] = 8'hFF;
      xfer(0, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'h5A);
      xfer(0, 8'h5A, 8'h5A, 1'b0, 1'b0, 8'h00);

      // Mode 3 against the slave model.
      s_word = 8'h3C;
      go(1, 8'hC3, 8'h3C, 1'b0);
      chk("slave_cap tx=c3", 32'(s_cap), 32'hC3);
      for (int i = 0; i < 4; i++) begin
         t = 8'($urandom); s = 8'($urandom);
         s_word = s;
         go(1, t, s, 1'b0);
         chk($sformatf("slave_cap tx=%0h", t), 32'(s_cap), 32'(t));
      end

      // CLK_DIV=1, 2-bit words.
      go(2, 8'h02, 8'h02, 1'b0);
      for (int i = 0; i < 4; i++) begin
         t = 8'($urandom_range(0, 3));
         go(2, t, t, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
